// File: rtl/fdiv_dispatch_pkg.sv
// Shared types and constants for the fdiv issue/collect stage.
// The divide-by-zero flag (enabled with FDIV_DISPATCH_DBZ_EN) uses the
// exponent field bounds and helper defined here.
package fdiv_dispatch_pkg;

    typedef logic [31:0] fp32_t;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;

    // A divisor whose exponent field is zero is either zero or denormal;
    // both are reported as a divide-by-zero.
    function automatic logic divisor_is_zero(input fp32_t b);
        return (b[EXP_MSB:EXP_LSB] == '0);
    endfunction

endpackage

// File: rtl/fdiv_dispatch_if.sv
// Request/response bus between the core and fdiv_dispatch.
// The master side issues divide requests and consumes results; the slave
// side is the dispatch stage. rsp_dbz exists only with FDIV_DISPATCH_DBZ_EN.
interface fdiv_dispatch_if
    import fdiv_dispatch_pkg::*;
#(
    parameter int TAG_W = 5
) ();

    logic             req_valid;
    logic             req_ready;
    fp32_t            req_a;
    fp32_t            req_b;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    fp32_t            rsp_y;
    logic [TAG_W-1:0] rsp_tag;
`ifdef FDIV_DISPATCH_DBZ_EN
    logic             rsp_dbz;
`endif

    modport master (
        output req_valid, req_a, req_b, req_tag, rsp_ready,
`ifdef FDIV_DISPATCH_DBZ_EN
        input  rsp_dbz,
`endif
        input  req_ready, rsp_valid, rsp_y, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, rsp_ready,
`ifdef FDIV_DISPATCH_DBZ_EN
        output rsp_dbz,
`endif
        output req_ready, rsp_valid, rsp_y, rsp_tag
    );

endinterface

// File: rtl/fdiv_dispatch_fifo.sv
// Synchronous result FIFO for fdiv_dispatch.
// Pointers wrap modulo DEPTH; the count is one bit wider than the pointers
// so that a full FIFO is distinguishable from an empty one. The head output
// reads as zero while the FIFO is empty.
module fdiv_dispatch_fifo #(
    parameter int  W     = 32,
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop
    // advances both pointers and leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because the head is masked
    // whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Credit admission upstream guarantees a free slot for every capture.
    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fdiv_dispatch.sv
// Issue and collect stage around the pipelined fdiv unit.
// Requests are registered onto fdiv_x1/x2, tracked by a valid/tag shift
// line that spans the fdiv latency plus the operand register, and the
// quotient is captured into a result FIFO. Admission is credit based:
// a request is accepted only while in-flight plus buffered results are
// below DEPTH, so a captured result always finds a FIFO slot.
// Optional divide-by-zero flag: define FDIV_DISPATCH_DBZ_EN.
module fdiv_dispatch
    import fdiv_dispatch_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fdiv_dispatch_if.slave bus,
    output fp32_t          fdiv_x1,
    output fp32_t          fdiv_x2,
    input  fp32_t          fdiv_y
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(DEPTH + LAT + 2) + 1;

    typedef struct packed {
        fp32_t            y;
        logic [TAG_W-1:0] tag;
`ifdef FDIV_DISPATCH_DBZ_EN
        logic             dbz;
`endif
    } rsp_entry_t;

    localparam int EW = $bits(rsp_entry_t);

    // Stage 0 is loaded at accept alongside the operand registers; the
    // entry in stage LAT is captured on the following edge, when fdiv_y
    // has had LAT edges to settle.
    logic [LAT:0]     sl_valid;
    logic [TAG_W-1:0] sl_tag [LAT+1];
`ifdef FDIV_DISPATCH_DBZ_EN
    logic [LAT:0]     sl_dbz;
`endif

    logic          accept;
    logic          capture;
    logic          pop;
    logic [OW-1:0] inflight;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    rsp_entry_t    push_entry;
    rsp_entry_t    head_entry;

    assign accept  = bus.req_valid && bus.req_ready;
    assign capture = sl_valid[LAT];
    assign pop     = bus.rsp_ready && !fifo_empty;

    // Operand registers only load on accept so fdiv inputs stay quiet
    // while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fdiv_x1 <= '0;
            fdiv_x2 <= '0;
        end else if (accept) begin
            fdiv_x1 <= bus.req_a;
            fdiv_x2 <= bus.req_b;
        end
    end

    // Valid/tag shift line following each operation through fdiv.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_valid <= '0;
            for (int i = 0; i <= LAT; i++) begin
                sl_tag[i] <= '0;
            end
        end else begin
            sl_valid[0] <= accept;
            sl_tag[0]   <= bus.req_tag;
            for (int i = 1; i <= LAT; i++) begin
                sl_valid[i] <= sl_valid[i-1];
                sl_tag[i]   <= sl_tag[i-1];
            end
        end
    end

`ifdef FDIV_DISPATCH_DBZ_EN
    // Divide-by-zero flag travels beside the tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_dbz <= '0;
        end else begin
            sl_dbz[0] <= divisor_is_zero(bus.req_b);
            for (int i = 1; i <= LAT; i++) begin
                sl_dbz[i] <= sl_dbz[i-1];
            end
        end
    end
`endif

    // Credits in use: every valid shift-line slot plus every buffered
    // result, all from registered state.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) begin
            inflight = inflight + OW'(sl_valid[i]);
        end
        occupancy = inflight + OW'(fifo_count);
    end

    assign bus.req_ready = (occupancy < OW'(DEPTH));

    // Result entry assembled from the quotient and the retiring slot.
    always_comb begin
        push_entry     = '0;
        push_entry.y   = fdiv_y;
        push_entry.tag = sl_tag[LAT];
`ifdef FDIV_DISPATCH_DBZ_EN
        push_entry.dbz = sl_dbz[LAT];
`endif
    end

    fdiv_dispatch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_y     = head_entry.y;
    assign bus.rsp_tag   = head_entry.tag;
`ifdef FDIV_DISPATCH_DBZ_EN
    assign bus.rsp_dbz   = head_entry.dbz;
`endif

endmodule
